// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
package mem_arb_pkg;

    // Which requester owns the memory port during the current cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_F = 2'd1,
        ISSUE_D = 2'd2
    } owner_t;

    localparam int unsigned ADDR_W_DEF     = 8;
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned STARVE_MAX_DEF = 3;
    localparam int unsigned STARVE_CNT_W   = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_ctr.sv
// Fetch starvation guard: counts consecutive fetch losses to the data port,
// saturating at STARVE_MAX, and raises force_f once the limit is reached.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CNT_W      = STARVE_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_f
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_f = (cnt_q == MAX_C);

endmodule : arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and
// load/store. The data port wins ties, a port is never granted two cycles in
// a row, and a starvation guard forces fetch through after repeated losses.
// Address/data/write-enable toward memory are registered in the grant cycle;
// read data comes back one cycle later and is qualified by a per-owner rvalid.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    // status
    output logic              busy
);

    owner_t            owner_q;
    owner_t            owner_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_wren_q;
    logic              mem_wren_d;
    logic              resp_valid_q;
    logic              resp_valid_d;
    logic              resp_is_f_q;
    logic              resp_is_f_d;

    logic              eligible_f;
    logic              eligible_d;
    logic              force_f;
    logic              starve_inc;
    logic              starve_clr;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (STARVE_CNT_W)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .force_f (force_f)
    );

    // Arbitration: pick next owner and the memory command it drives.
    always_comb begin
        eligible_f  = f_req & (owner_q != ISSUE_F);
        eligible_d  = d_req & (owner_q != ISSUE_D);

        owner_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;

        if (force_f && eligible_f) begin
            owner_d = ISSUE_F;
        end else if (eligible_d) begin
            owner_d = ISSUE_D;
        end else if (eligible_f) begin
            owner_d = ISSUE_F;
        end

        case (owner_d)
            ISSUE_F: begin
                mem_addr_d = f_addr;
            end
            ISSUE_D: begin
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_wren_d  = d_we;
            end
            default: begin
            end
        endcase

        starve_inc = eligible_f & (owner_d == ISSUE_D);
        starve_clr = (owner_d == ISSUE_F) | ~f_req;
    end

    // Response stage input: a read issued this cycle returns data next cycle.
    always_comb begin
        resp_is_f_d  = (owner_q == ISSUE_F);
        resp_valid_d = (owner_q == ISSUE_F) | ((owner_q == ISSUE_D) & ~mem_wren_q);
    end

    // Issue, memory command and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wren_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_is_f_q  <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wren_q   <= mem_wren_d;
            resp_valid_q <= resp_valid_d;
            resp_is_f_q  <= resp_is_f_d;
        end
    end

    assign f_gnt     = (owner_q == ISSUE_F);
    assign d_gnt     = (owner_q == ISSUE_D);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

    assign f_rvalid  = resp_valid_q & resp_is_f_q;
    assign d_rvalid  = resp_valid_q & ~resp_is_f_q;
    assign f_rdata   = mem_q;
    assign d_rdata   = mem_q;

    assign busy      = (owner_q != IDLE) | resp_valid_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed request streams, a sync-read memory,
// a transaction-level reference model checked every cycle, plus literal checks.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_q;
    logic          mem_wren, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    // Synchronous-read memory attached to the arbiter.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which port was granted last cycle, the fetch
    // loss count, and the read data that each issued read must return.
    int            m_gnt = 0;       // 0 none, 1 fetch, 2 data
    int            m_starve = 0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_issue_rdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_rv_f = 1'b0;
    bit            m_rv_d = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_on = 1'b0;

    always @(posedge clk) begin : model
        int ng;
        bit ef, ed;
        if (rst) begin
            m_gnt    <= 0;
            m_starve <= 0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rv_f   <= 1'b0;
            m_rv_d   <= 1'b0;
            m_busy   <= 1'b0;
        end else begin
            ef = f_req && (m_gnt != 1);
            ed = d_req && (m_gnt != 2);
            if (m_starve == SM && ef) ng = 1;
            else if (ed)              ng = 2;
            else if (ef)              ng = 1;
            else                      ng = 0;
            m_rv_f  <= (m_gnt == 1);
            m_rv_d  <= (m_gnt == 2) && !m_we;
            m_rdata <= m_issue_rdata;
            if (ng == 1 || !f_req) m_starve <= 0;
            else if (ef && ng == 2 && m_starve < SM) m_starve <= m_starve + 1;
            m_gnt <= ng;
            m_we  <= (ng == 2) && d_we;
            if (ng == 1) begin
                m_addr        <= f_addr;
                m_issue_rdata <= ref_mem[f_addr];
            end else if (ng == 2) begin
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                if (d_we) ref_mem[d_addr] <= d_wdata;
                else      m_issue_rdata   <= ref_mem[d_addr];
            end
            m_busy <= (ng != 0) || (m_gnt == 1) || ((m_gnt == 2) && !m_we);
        end
        m_on <= 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("f_gnt",     f_gnt,     m_gnt == 1);
            chk("d_gnt",     d_gnt,     m_gnt == 2);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wren",  mem_wren,  m_we);
            chk("f_rvalid",  f_rvalid,  m_rv_f);
            chk("d_rvalid",  d_rvalid,  m_rv_d);
            chk("busy",      busy,      m_busy);
            if (m_rv_f) chk("f_rdata", f_rdata, m_rdata);
            if (m_rv_d) chk("d_rdata", d_rdata, m_rdata);
        end
    end

    // Requester driver: each queue head is held until its grant is seen.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dop_t;

    logic [AW-1:0] fq[$];
    dop_t          dq[$];
    int            gl[$];
    int            f_rv_cnt = 0;
    int            d_rv_cnt = 0;

    task automatic drive_heads();
        f_req  = (fq.size() > 0);
        f_addr = (fq.size() > 0) ? fq[0] : '0;
        d_req  = (dq.size() > 0);
        if (dq.size() > 0) begin
            d_we    = dq[0].we;
            d_addr  = dq[0].addr;
            d_wdata = dq[0].wdata;
        end else begin
            d_we    = 1'b0;
            d_addr  = '0;
            d_wdata = '0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (f_gnt) begin
            gl.push_back(1);
            if (fq.size() > 0) void'(fq.pop_front());
        end
        if (d_gnt) begin
            gl.push_back(2);
            if (dq.size() > 0) void'(dq.pop_front());
        end
        if (f_rvalid) f_rv_cnt++;
        if (d_rvalid) d_rv_cnt++;
        drive_heads();
    endtask

    task automatic run(input int budget);
        int i = 0;
        drive_heads();
        while ((fq.size() > 0 || dq.size() > 0) && i < budget) begin
            cycle();
            i++;
        end
        chk("drain_in_budget", (fq.size() == 0 && dq.size() == 0), 1);
        repeat (3) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, nd;
        bit seen;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 16'h0101) ^ 16'h5A5A;
            ref_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
        end
        mem[8'h12]     = 16'hBEEF;
        ref_mem[8'h12] = 16'hBEEF;

        // 1: reset held with both requests up
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        f_addr = 8'h40; d_addr = 8'h41; d_wdata = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_f_gnt", f_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wren", mem_wren, 0);
            chk("rst_rvalid", {f_rvalid, d_rvalid}, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_d_gnt", d_gnt, 1);
        chk("first_f_gnt", f_gnt, 0);
        f_req = 1'b0; d_req = 1'b0;   // fetch withdraws without ever being granted
        repeat (3) cycle();

        // 2: single load
        dq.push_back('{we: 1'b0, addr: 8'h12, wdata: 16'h0});
        drive_heads();
        cycle();
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_mem_addr", mem_addr, 8'h12);
        chk("t2_mem_wren", mem_wren, 0);
        cycle();
        chk("t2_d_rvalid", d_rvalid, 1);
        chk("t2_d_rdata", d_rdata, 16'hBEEF);
        repeat (2) cycle();

        // 3: store then load back
        dq.push_back('{we: 1'b1, addr: 8'h05, wdata: 16'h00A5});
        dq.push_back('{we: 1'b0, addr: 8'h05, wdata: 16'h0});
        drive_heads();
        cycle();
        chk("t3_st_gnt", d_gnt, 1);
        chk("t3_st_wren", mem_wren, 1);
        chk("t3_st_addr", mem_addr, 8'h05);
        chk("t3_st_wdata", mem_wdata, 16'h00A5);
        cycle();
        chk("t3_no_rvalid", d_rvalid, 0);
        chk("t3_wren_pulse", mem_wren, 0);
        cycle();
        chk("t3_ld_gnt", d_gnt, 1);
        cycle();
        chk("t3_ld_rvalid", d_rvalid, 1);
        chk("t3_ld_rdata", d_rdata, 16'h00A5);
        repeat (2) cycle();

        // 4: continuous contention
        for (int i = 0; i < 8; i++) begin
            fq.push_back(AW'(8'h20 + i));
            dq.push_back('{we: 1'b0, addr: AW'(8'h30 + i), wdata: 16'h0});
        end
        gl.delete();
        f0 = f_rv_cnt; d0 = d_rv_cnt;
        run(40);
        chk("t4_grant_count", gl.size(), 16);
        chk("t4_g0_D", gl[0], 2);
        chk("t4_g1_F", gl[1], 1);
        chk("t4_g2_D", gl[2], 2);
        chk("t4_g3_F", gl[3], 1);
        chk("t4_f_rvalids", f_rv_cnt - f0, 8);
        chk("t4_d_rvalids", d_rv_cnt - d0, 8);

        // 5: data stream kept up, fetch must get through
        for (int i = 0; i < 6; i++) begin
            dq.push_back('{we: 1'(i % 2), addr: AW'(8'h60 + i), wdata: DW'(16'h1000 + i)});
        end
        fq.push_back(8'h70);
        fq.push_back(8'h71);
        gl.delete();
        run(40);
        nd = 0; seen = 1'b0;
        foreach (gl[i]) begin
            if (!seen) begin
                if (gl[i] == 1) seen = 1'b1;
                else            nd++;
            end
        end
        chk("t5_fetch_granted", seen, 1);
        chk("t5_starve_bound", nd <= SM, 1);

        // 6: reset while a load is in flight
        dq.push_back('{we: 1'b0, addr: 8'h12, wdata: 16'h0});
        drive_heads();
        cycle();
        chk("t6_d_gnt", d_gnt, 1);
        rst = 1'b1;
        dq.delete();
        drive_heads();
        cycle();
        chk("t6_rvalid_dropped", d_rvalid, 0);
        chk("t6_busy_in_rst", busy, 0);
        rst = 1'b0;
        cycle();
        chk("t6_rvalid_after", d_rvalid, 0);
        chk("t6_busy_after", busy, 0);
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
